// File: rtl/serial_add.sv
// Digit-serial adder: adds DIGIT bits per clock over N = WIDTH/DIGIT RUN cycles.
// Latency: done pulses N+1 cycles after the accept cycle; ready only in IDLE.
// Optional subtract path is built only when SERIAL_ADD_SUB_EN is defined.
module serial_add #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] val0,
  input  logic [WIDTH-1:0] val1,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cy;
  logic [KW-1:0]    k;
  logic             last_digit;
  logic             accept;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT:0]   dig_sum;
  logic             msb_cin;
  logic [WIDTH-1:0] b_in;
  logic             cin0;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract is a + ~b + 1: invert the second operand and seed the carry.
  assign b_in = sub ? ~val1 : val1;
  assign cin0 = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = val1;
  assign cin0       = 1'b0;
`endif

  assign accept     = start && ready;
  assign last_digit = (k == KW'(N - 1));
  assign dig_a      = op_a[k*DIGIT +: DIGIT];
  assign dig_b      = op_b[k*DIGIT +: DIGIT];
  assign dig_sum    = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, cy};
  // Carry into the MSB recovered from the MSB's inputs and its sum bit.
  assign msb_cin    = dig_a[DIGIT-1] ^ dig_b[DIGIT-1] ^ dig_sum[DIGIT-1];

  // State register; reset wins over a simultaneous start.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and one digit of addition per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      cy       <= 1'b0;
      k        <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_a     <= val0;
      op_b     <= b_in;
      cy       <= cin0;
      k        <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      sum[k*DIGIT +: DIGIT] <= dig_sum[DIGIT-1:0];
      cy <= dig_sum[DIGIT];
      k  <= k + KW'(1);
      if (last_digit) begin
        carry    <= dig_sum[DIGIT];
        overflow <= msb_cin ^ dig_sum[DIGIT];
      end
    end
  end

endmodule
